// File: rtl/uc_pkg.sv
// uc_pkg: shared FSM state, opcode class and ALU op constants for the uc_ctrl control unit.
package uc_pkg;
    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_e;
    typedef logic [2:0] alu_op_t;
    localparam alu_op_t    ALU_DEF  = 3'b000;
    localparam logic [3:0] OPC_LI   = 4'b1000;
    localparam logic [5:0] OPC_J    = 6'b100100;
    localparam logic [5:0] OPC_JZ   = 6'b100101;
    localparam logic [5:0] OPC_JNZ  = 6'b100110;
    localparam logic [5:0] OPC_HALT = 6'b100111;
    localparam logic [3:0] OPC_NOP  = 4'b1010;
endpackage

// File: rtl/uc_decode.sv
// uc_decode: pure combinational Opcode/z to control-signal decode.
// The taken-jump output exists only when UC_PERFCNT_EN is defined.
module uc_decode
    import uc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       z,
    output logic       s_inc,
    output logic       s_inm,
    output logic       we3,
    output logic       wez,
    output alu_op_t    op,
    output logic       halt,
    output logic       legal
`ifdef UC_PERFCNT_EN
    , output logic     taken
`endif
);
    logic alu, li, j, jz, jnz, nop;
    always_comb begin
        alu   = ~opcode[5];
        li    = opcode[5:2] == OPC_LI;
        j     = opcode == OPC_J;
        jz    = opcode == OPC_JZ;
        jnz   = opcode == OPC_JNZ;
        halt  = opcode == OPC_HALT;
        nop   = opcode[5:2] == OPC_NOP;
        legal = alu | li | j | jz | jnz | halt | nop;
        s_inc = (j | halt) ? 1'b0 : jz ? ~z : jnz ? z : 1'b1;
        s_inm = li;
        we3   = alu | li;
        wez   = alu;
        op    = alu ? opcode[4:2] : ALU_DEF;
`ifdef UC_PERFCNT_EN
        taken = j | (jz & z) | (jnz & ~z);
`endif
    end
endmodule

// File: rtl/uc_ctrl.sv
// uc_ctrl: BOOT/RUN/HALT sequenced control unit with sticky illegal-opcode flag.
// Define UC_PERFCNT_EN to add saturating retired / jumps_taken counters.
module uc_ctrl
    import uc_pkg::*;
#(
    parameter int BOOT_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             z,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output alu_op_t          Op,
    output logic             halted,
    output logic             illegal
`ifdef UC_PERFCNT_EN
    , output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] jumps_taken
`endif
);
    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BW-1:0] BOOT_INIT = BW'((BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0);
    localparam state_e ST_INIT = (BOOT_CYCLES > 0) ? ST_BOOT : ST_RUN;

    state_e          state_q, state_d;
    logic [BW-1:0]   boot_cnt_q, boot_cnt_d;
    logic            illegal_q, illegal_d;
    logic            d_s_inc, d_s_inm, d_we3, d_wez, d_halt, d_legal, run;
    alu_op_t         d_op;
`ifdef UC_PERFCNT_EN
    logic             d_taken;
    logic [CNT_W-1:0] retired_q, retired_d, jumps_q, jumps_d;
`endif

    uc_decode u_dec (
        .opcode (Opcode),
        .z      (z),
        .s_inc  (d_s_inc),
        .s_inm  (d_s_inm),
        .we3    (d_we3),
        .wez    (d_wez),
        .op     (d_op),
        .halt   (d_halt),
        .legal  (d_legal)
`ifdef UC_PERFCNT_EN
        , .taken (d_taken)
`endif
    );

    always_comb begin
        run        = state_q == ST_RUN;
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        illegal_d  = illegal_q | (run & ~d_legal);
        if (state_q == ST_BOOT) begin
            if (boot_cnt_q == '0) state_d = ST_RUN;
            else boot_cnt_d = boot_cnt_q - BW'(1);
        end
        if (run && d_halt) state_d = ST_HALT;
        // HALT forces a self-loop on the PC; BOOT just lets the PC advance while memory warms up
        s_inc   = (state_q == ST_HALT) ? 1'b0 : run ? d_s_inc : 1'b1;
        s_inm   = run & d_s_inm;
        we3     = run & d_we3;
        wez     = run & d_wez;
        Op      = run ? d_op : ALU_DEF;
        halted  = state_q == ST_HALT;
        illegal = illegal_q;
`ifdef UC_PERFCNT_EN
        retired_d   = (run && d_legal && !(&retired_q)) ? retired_q + CNT_W'(1) : retired_q;
        jumps_d     = (run && d_taken && !(&jumps_q)) ? jumps_q + CNT_W'(1) : jumps_q;
        retired     = retired_q;
        jumps_taken = jumps_q;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            boot_cnt_q <= BOOT_INIT;
            illegal_q  <= 1'b0;
`ifdef UC_PERFCNT_EN
            retired_q  <= '0;
            jumps_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            illegal_q  <= illegal_d;
`ifdef UC_PERFCNT_EN
            retired_q  <= retired_d;
            jumps_q    <= jumps_d;
`endif
        end
    end
endmodule

// File: tb/tb_uc_ctrl.sv
// tb_uc_ctrl: directed vectors with a queue-based scoreboard for uc_ctrl (BOOT_CYCLES=1).
module tb_uc_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] Opcode = 6'b000100;
    logic       z = 1'b0;
    logic       s_inc, s_inm, we3, wez, halted, illegal;
    logic [2:0] Op;
`ifdef UC_PERFCNT_EN
    logic [15:0] retired, jumps_taken;
`endif

    uc_ctrl #(.BOOT_CYCLES(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .z(z),
        .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
        .halted(halted), .illegal(illegal)
`ifdef UC_PERFCNT_EN
        , .retired(retired), .jumps_taken(jumps_taken)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] ctl;
        int         ret;
        int         jmp;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    // ctl packing: {s_inc, s_inm, we3, wez, Op[2:0], halted, illegal}
    localparam logic [8:0] C_BOOT  = 9'b1000_000_00;
    localparam logic [8:0] C_A001  = 9'b1011_001_00;
    localparam logic [8:0] C_A111  = 9'b1011_111_00;
    localparam logic [8:0] C_LI    = 9'b1110_000_00;
    localparam logic [8:0] C_JMP   = 9'b0000_000_00;
    localparam logic [8:0] C_NOP   = 9'b1000_000_00;
    localparam logic [8:0] C_NOPI  = 9'b1000_000_01;
    localparam logic [8:0] C_HLTI  = 9'b0000_000_01;
    localparam logic [8:0] C_HST   = 9'b0000_000_11;

    task automatic step(input logic rst, input logic [5:0] opc, input logic zz,
                        input logic [8:0] ctl, input int ret, input int jmp, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset  = rst;
        Opcode = opc;
        z      = zz;
        e.ctl = ctl;
        e.ret = ret;
        e.jmp = jmp;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            string      nm;
            logic [8:0] got;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {s_inc, s_inm, we3, wez, Op, halted, illegal};
            checks++;
            if (got !== e.ctl) begin
                errors++;
                $display("FAIL %s ctl got %b want %b", nm, got, e.ctl);
            end
`ifdef UC_PERFCNT_EN
            checks++;
            if (retired !== 16'(e.ret) || jumps_taken !== 16'(e.jmp)) begin
                errors++;
                $display("FAIL %s counters got ret=%0d jmp=%0d want ret=%0d jmp=%0d",
                         nm, retired, jumps_taken, e.ret, e.jmp);
            end
`endif
        end
    end

    initial begin
        step(1'b0, 6'b000100, 1'b0, C_BOOT, 0, 0, "reset_state");
        step(1'b1, 6'b000100, 1'b0, C_BOOT, 0, 0, "boot_cycle");
        step(1'b1, 6'b000100, 1'b0, C_A001, 0, 0, "run_alu001");
        step(1'b1, 6'b011111, 1'b0, C_A111, 1, 0, "run_alu111");
        step(1'b1, 6'b100001, 1'b0, C_LI,   2, 0, "li");
        step(1'b1, 6'b100101, 1'b1, C_JMP,  3, 0, "jz_taken");
        step(1'b1, 6'b100101, 1'b0, C_NOP,  4, 1, "jz_not_taken");
        step(1'b1, 6'b100110, 1'b1, C_NOP,  5, 1, "jnz_not_taken");
        step(1'b1, 6'b100110, 1'b0, C_JMP,  6, 1, "jnz_taken");
        step(1'b1, 6'b100100, 1'b0, C_JMP,  7, 2, "j");
        step(1'b1, 6'b101011, 1'b0, C_NOP,  8, 3, "nop");
        step(1'b1, 6'b110000, 1'b0, C_NOP,  9, 3, "illegal_11");
        step(1'b1, 6'b101100, 1'b0, C_NOPI, 9, 3, "illegal_sticky");
        step(1'b1, 6'b100111, 1'b0, C_HLTI, 9, 3, "halt_instr");
        step(1'b1, 6'b000000, 1'b0, C_HST, 10, 3, "halt_alu_blocked");
        step(1'b1, 6'b100100, 1'b1, C_HST, 10, 3, "halt_jump_blocked");
        step(1'b0, 6'b000100, 1'b0, C_BOOT, 0, 0, "reset_from_halt");
        step(1'b1, 6'b110000, 1'b0, C_BOOT, 0, 0, "boot_illegal_ignored");
        step(1'b1, 6'b000100, 1'b0, C_A001, 0, 0, "run2_a");
        step(1'b1, 6'b000100, 1'b0, C_A001, 1, 0, "run2_b");
        step(1'b1, 6'b100001, 1'b0, C_LI,   2, 0, "run2_li");
        step(1'b1, 6'b101000, 1'b0, C_NOP,  3, 0, "run2_nop");
        step(1'b1, 6'b000100, 1'b0, C_A001, 4, 0, "run2_c");
        step(1'b1, 6'b110000, 1'b0, C_NOP,  5, 0, "run2_illegal");
        step(1'b0, 6'b000100, 1'b0, C_BOOT, 0, 0, "async_reset_mid_run");
        step(1'b1, 6'b000100, 1'b0, C_BOOT, 0, 0, "boot_after_async");
        repeat (5) begin
            if (exp_q.size() > 0) @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
